// File: rtl/demod_pkg.sv
// Shared types and defaults for the sample-stream demodulator.
package demod_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int SAMPLES_PER_BIT_DEFAULT = 32;
  localparam int MIDSCALE_DEFAULT        = 128;
  localparam int THRESHOLD_DEFAULT       = 1024;
  localparam int BITS_PER_BYTE_DEFAULT   = 8;

  // A full window of 9-bit signed terms fits without overflow.
  function automatic int acc_width(input int spb);
    return $clog2(spb) + 9;
  endfunction

endpackage

// File: rtl/demod_bit_integrator.sv
// Integrates one bit window of samples about midscale and slices the bit.
// bit_done/bit_val/sign are combinational and valid on the window's last sample.
import demod_pkg::*;

module demod_bit_integrator #(
  parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEFAULT,
  parameter int MIDSCALE        = MIDSCALE_DEFAULT,
  parameter int THRESHOLD       = THRESHOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       sample_en,
  input  logic [7:0] amostra,
  output logic       bit_done,
  output logic       bit_val,
  output logic       sign
);

  localparam int AW = acc_width(SAMPLES_PER_BIT);
  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam logic [AW:0]   THR  = (AW+1)'(THRESHOLD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_BIT - 1);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] sum;
  logic        [AW-1:0] mag;
  logic        [CW-1:0] cnt;
  logic                 last;

  // Signed sample term and the running window sum including it.
  always_comb begin
    term = $signed({{(AW-8){1'b0}}, amostra}) - $signed(AW'(MIDSCALE));
    sum  = acc + term;
    // The most negative sum negates to itself, which is still the right
    // magnitude when read unsigned.
    mag  = sum[AW-1] ? AW'(-sum) : AW'(sum);
    last = (cnt == LAST);
  end

  assign bit_done = sample_en & ~clear & last;
  assign bit_val  = ({1'b0, mag} >= THR);
  assign sign     = sum[AW-1];

  // Accumulator and sample counter; a clear with a valid sample makes it sample 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= sample_en ? term : '0;
      cnt <= sample_en ? CW'(1) : '0;
    end else if (sample_en) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/demodulador.sv
// Sample-stream demodulator: bit-window integration, byte assembly, byte strobe.
// Optional macro DEMOD_POLARITY_CHECK_EN adds erro_pol, a sticky flag raised when
// two successive bit-1 windows share the same sum sign.
import demod_pkg::*;

module demodulador #(
  parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEFAULT,
  parameter int MIDSCALE        = MIDSCALE_DEFAULT,
  parameter int THRESHOLD       = THRESHOLD_DEFAULT,
  parameter int BITS_PER_BYTE   = BITS_PER_BYTE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               amostra,
  input  logic                     amostra_valid,
  input  logic                     start,
  output logic [BITS_PER_BYTE-1:0] dado,
  output logic                     flag_byte,
  output logic                     status
`ifdef DEMOD_POLARITY_CHECK_EN
  , output logic                   erro_pol
`endif
);

  localparam int BW = $clog2(BITS_PER_BYTE);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_BYTE - 1);

  state_t                   state_q, state_d;
  logic [BW-1:0]            bit_cnt;
  logic [BITS_PER_BYTE-1:0] shreg;
  logic [BITS_PER_BYTE-1:0] byte_next;
  logic                     sample_en;
  logic                     bit_done, bit_val, sign;

  // Start accepts its own sample even while still in IDLE.
  assign sample_en = amostra_valid & ((state_q == RUN) | start);
  assign status    = (state_q == RUN);

  demod_bit_integrator #(
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .MIDSCALE        (MIDSCALE),
    .THRESHOLD       (THRESHOLD)
  ) u_int (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start),
    .sample_en (sample_en),
    .amostra   (amostra),
    .bit_done  (bit_done),
    .bit_val   (bit_val),
    .sign      (sign)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: only start leaves IDLE; RUN is held until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Byte image including the bit being sliced this cycle.
  always_comb begin
    byte_next          = shreg;
    byte_next[bit_cnt] = bit_val;
  end

  // Bit counter, shift register, output byte and one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      dado      <= '0;
      flag_byte <= 1'b0;
    end else begin
      flag_byte <= 1'b0;
      if (start) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (bit_done) begin
        shreg <= byte_next;
        if (bit_cnt == LAST_BIT) begin
          dado      <= byte_next;
          flag_byte <= 1'b1;
          bit_cnt   <= '0;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

`ifdef DEMOD_POLARITY_CHECK_EN
  logic sign_q, sign_seen;

  // Bit-1 lobes must alternate sign; a repeat sets the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q    <= 1'b0;
      sign_seen <= 1'b0;
      erro_pol  <= 1'b0;
    end else if (start) begin
      sign_q    <= 1'b0;
      sign_seen <= 1'b0;
      erro_pol  <= 1'b0;
    end else if (bit_done && bit_val) begin
      if (sign_seen && (sign == sign_q)) erro_pol <= 1'b1;
      sign_q    <= sign;
      sign_seen <= 1'b1;
    end
  end
`else
  logic unused_sign;
  assign unused_sign = sign;
`endif

endmodule

// File: tb/tb_demodulador.sv
// Directed bench for demodulador with a queue-based byte scoreboard.
module tb_demodulador;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] amostra = 8'd128;
  logic       amostra_valid = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dado;
  logic       flag_byte;
  logic       status;
`ifdef DEMOD_POLARITY_CHECK_EN
  logic       erro_pol;
`endif

  demodulador dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .amostra       (amostra),
    .amostra_valid (amostra_valid),
    .start         (start),
    .dado          (dado),
    .flag_byte     (flag_byte),
    .status        (status)
`ifdef DEMOD_POLARITY_CHECK_EN
    , .erro_pol    (erro_pol)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int c; } exp_t;
  exp_t sbq[$];
  exp_t e_mon;

  int n_vec = 0;
  int n_err = 0;
  int pol = 1;
  int lobe[32];
  int dsin[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected byte and its cycle.
  always @(negedge clk) begin
    if (rst_n && flag_byte === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe", 32'(flag_byte), 32'd0);
      end else begin
        e_mon = sbq.pop_front();
        check("dado", 32'(dado), 32'(e_mon.d));
        check("strobe_cycle", 32'(cyc), 32'(e_mon.c));
        check("status_at_strobe", 32'(status), 32'd1);
      end
    end
  end

  task automatic drive(input int s, input bit st);
    @(negedge clk);
    amostra       = 8'(s);
    amostra_valid = 1'b1;
    start         = st;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      amostra_valid = 1'b0;
      start         = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    amostra_valid = 1'b0;
    start         = 1'b1;
    pol           = 1;
  endtask

  // Called right after driving a byte's last sample: strobe lands next cycle.
  task automatic expect_byte(input logic [7:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic send_bit(input bit b, input bit st, input int gap_at);
    for (int i = 0; i < 32; i++) begin
      if (i == gap_at) idle(50);
      drive(b ? 128 + pol * lobe[i] : 128 + dsin[i], st && (i == 0));
    end
    if (b) pol = -pol;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit st, input int gap_bit, input bit push);
    if (st) pol = 1;
    for (int k = 0; k < 8; k++)
      send_bit(v[k], st && (k == 0), (k == gap_bit) ? 10 : -1);
    if (push) expect_byte(v);
  endtask

  task automatic send_const(input int v);
    for (int i = 0; i < 32; i++) drive(v, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      lobe[i] = int'(127.0 * $sin(3.14159265358979 * i / 32.0));
      dsin[i] = int'(100.0 * $sin(2.0 * 3.14159265358979 * 2.0 * i / 32.0));
    end

    // Reset state
    #1;
    check("rst_dado", 32'(dado), 32'd0);
    check("rst_flag", 32'(flag_byte), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("idle_status", 32'(status), 32'd0);

    // Samples without start are ignored
    send_byte(8'hFF, 1'b0, -1, 1'b0);
    idle(5);
    check("idle_ignores", 32'(status), 32'd0);

    // 0xA5 loopback
    pulse_start();
    send_byte(8'hA5, 1'b0, -1, 1'b1);
    idle(3);
    check("run_status", 32'(status), 32'd1);

    // Reset mid-byte: 100 bit-1 samples then asynchronous reset
    for (int i = 0; i < 100; i++) begin
      drive(128 + pol * lobe[i % 32], 1'b0);
      if ((i % 32) == 31) pol = -pol;
    end
    @(negedge clk);
    amostra_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dado", 32'(dado), 32'd0);
    check("async_rst_flag", 32'(flag_byte), 32'd0);
    check("async_rst_status", 32'(status), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(300);

    // Back-to-back 0x00, 0xFF
    pulse_start();
    send_byte(8'h00, 1'b0, -1, 1'b1);
    send_byte(8'hFF, 1'b0, -1, 1'b1);
    idle(3);

    // Threshold boundary: 160 -> 1, 159 -> 0, 96 -> 1
    pulse_start();
    send_const(160);
    send_const(159);
    send_const(96);
    for (int k = 3; k < 8; k++) send_bit(1'b0, 1'b0, -1);
    expect_byte(8'h05);
    idle(3);

    // Resync after 3 bits, start coincident with sample 0 of 0x3C
    pulse_start();
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0, -1);
    send_byte(8'h3C, 1'b1, -1, 1'b1);
    // Gap of 50 cycles inside bit 2
    send_byte(8'h3C, 1'b0, 2, 1'b1);
    idle(3);

`ifdef DEMOD_POLARITY_CHECK_EN
    check("pol_after_3c", 32'(erro_pol), 32'd0);
    pulse_start();
    send_byte(8'hFF, 1'b0, -1, 1'b1);
    idle(2);
    check("pol_alt_ff", 32'(erro_pol), 32'd0);
    pulse_start();
    send_bit(1'b1, 1'b0, -1);
    pol = 1;
    send_bit(1'b1, 1'b0, -1);
    idle(2);
    check("pol_repeat_set", 32'(erro_pol), 32'd1);
    for (int k = 2; k < 8; k++) send_bit(1'b0, 1'b0, -1);
    expect_byte(8'h03);
    idle(3);
    check("pol_sticky", 32'(erro_pol), 32'd1);
    pulse_start();
    idle(2);
    check("pol_cleared", 32'(erro_pol), 32'd0);
`endif

    check("queue_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demodulador.md
Name: demodulador

Overview:
- Receive-side counterpart of the team's sample-table modulator.
- Consumes the 8-bit sample stream the modulator drives to the DAC: 32 samples per bit, bytes sent LSB first, midscale 128.
- Bit 0 is two full sine periods per bit window, so its sum about midscale is near zero. Bit 1 is one half-sine lobe per window whose polarity alternates, so its sum is large in magnitude.
- Integrates each bit window, slices the bit, assembles bytes and presents each byte with a one-cycle strobe to the downstream byte consumer.

Parameters:
- SAMPLES_PER_BIT, 32, samples per bit window; power of two, 4..256.
- MIDSCALE, 128, unsigned sample value treated as zero.
- THRESHOLD, 1024, minimum |window sum| that decodes as bit 1.
- BITS_PER_BYTE, 8, bits assembled per output byte.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- amostra, input, 8, unsigned sample from the ADC/loopback; qualified by amostra_valid.
- amostra_valid, input, 1, sample strobe; one sample accepted per clk while high.
- start, input, 1, one-cycle pulse that aligns the receiver to a bit/byte boundary.
- dado, output, 8, last received byte, LSB = first bit received.
- flag_byte, output, 1, one-cycle pulse; dado is valid and updated in this cycle.
- status, output, 1, 1 while in RUN state, 0 in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, dado=0, flag_byte=0, status=0. Accumulator, sample counter, bit counter and shift register are cleared.
- FSM states:
  - IDLE: samples are ignored.
  - IDLE->RUN on start=1.
  - RUN->RUN on start=1: resynchronisation. Counters and accumulator are cleared and any partial byte is discarded; no flag_byte is issued.
  - No exit to IDLE except reset.
- Start cycle: if amostra_valid=1 in the same cycle as start, that sample is accepted as sample 0 of bit 0. Start takes precedence over normal counting.
- Per accepted sample in RUN: acc <= acc + (amostra - MIDSCALE), signed.
  - acc width = $clog2(SAMPLES_PER_BIT)+9 bits, which cannot overflow; no saturation logic.
- Window end (sample counter = SAMPLES_PER_BIT-1 and sample accepted):
  - Final sum = acc + current sample term, computed combinationally.
  - bit = (|sum| >= THRESHOLD).
  - The bit is written to shift register position bit_cnt; acc and sample counter are cleared on the same edge.
- Byte end (bit_cnt = BITS_PER_BYTE-1 at window end):
  - dado is loaded with the completed byte, flag_byte=1 for exactly one clk, and bit_cnt wraps to 0.
  - Latency: flag_byte is high in the cycle immediately after the edge that accepts sample SAMPLES_PER_BIT*BITS_PER_BYTE of the byte.
- dado holds its value until the next byte completes. Reception is continuous: the next byte starts with the following accepted sample.
- amostra_valid low: counters and acc hold, and no timeout applies. Gaps are transparent.
- flag_byte never asserts in IDLE, in the cycle after reset release, or on a start-aborted byte.

Optional Feature:
- Macro: DEMOD_POLARITY_CHECK_EN.
- When defined:
  - Adds output erro_pol (1 bit, reset 0).
  - For every decoded bit 1, the sign of its window sum is compared with the sign of the previous bit-1 window since start.
  - Equal signs set erro_pol sticky high; it is cleared only by start or reset.
  - The first bit 1 after start only records its sign.
- When undefined: no erro_pol port, no sign register; behaviour otherwise identical.

Decomposition:
- Package demod_pkg holds:
  - state_t enum {IDLE, RUN};
  - localparam defaults;
  - acc width function;
  - localparam MIDSCALE_DEFAULT.
- Sub-module demod_bit_integrator:
  - Contains the signed accumulator, sample counter and threshold slicer.
  - Outputs bit_done, bit_val and sign.
- The top module holds the FSM, bit counter, shift register, dado/flag_byte and the optional polarity check.

Test Plan:
- Reset mid-byte: drive 100 samples of bit-1 lobes, then pulse rst_n low -> dado=0x00, flag_byte=0, status=0 immediately and asynchronously; no strobe follows.
- Byte 0xA5 loopback: start, then 256 modulator-table samples (bit1 lobe alternating ±, bit0 double sine) -> flag_byte exactly once, one cycle after sample 256, with dado=0xA5 and status=1.
- Back-to-back 0x00 then 0xFF: 512 contiguous samples -> two flag_byte pulses 256 clk apart, with dado=0x00 then 0xFF.
- Threshold boundary, one window each:
  - constant 160 (sum 1024) -> bit 1;
  - constant 159 (sum 992) -> bit 0;
  - constant 96 (sum -1024) -> bit 1.
- Resync and gaps:
  - start issued after 3 bits of a byte -> no strobe; a following full byte 0x3C decodes correctly.
  - amostra_valid low for 50 cycles mid-window -> same result.
- With DEMOD_POLARITY_CHECK_EN, two consecutive positive bit-1 lobes -> erro_pol=1 until the next start; correctly alternating 0xFF -> erro_pol stays 0.
